// File: rtl/ahb_pkg.sv
// Shared AHB types for the bridge-side arbiter: transfer kinds, responses and arbiter states.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    PARK,
    OWNED,
    LOCKED
  } arb_state_t;

  // A beat that moves data; BUSY and IDLE do not.
  function automatic logic is_beat(htrans_t t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first requester strictly after ptr_i, wrapping, with ptr_i itself last.
module rr_priority_picker #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  always_comb begin : pick
    int unsigned j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      j = (32'(ptr_i) + k) % NumReq;
      if (!valid_o && req_i[IdxW'(j)]) begin
        valid_o           = 1'b1;
        idx_o             = IdxW'(j);
        gnt_o[IdxW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB arbiter sharing the AHB-to-APB bridge port; tracks address- and data-phase
// owners separately, enforces a beat budget for unlocked owners and honours locked transfers.
module ahb_bridge_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned DEF_MASTER  = 0,
  parameter int unsigned MAX_BEATS   = 16,
  localparam int unsigned IdxW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      Hclk,
  input  logic                      Hresetn,
  input  logic [NUM_MASTERS-1:0]    Hbusreq,
  input  logic [NUM_MASTERS-1:0]    Hlock,
  input  logic [2*NUM_MASTERS-1:0]  Htrans_m,
  input  logic [32*NUM_MASTERS-1:0] Haddr_m,
  input  logic [NUM_MASTERS-1:0]    Hwrite_m,
  input  logic [32*NUM_MASTERS-1:0] Hwdata_m,
  input  logic                      Hready,
  output logic [NUM_MASTERS-1:0]    Hgrant,
  output logic [IdxW-1:0]           Hmaster,
  output logic [IdxW-1:0]           Hmaster_d,
  output logic                      Hmastlock,
  output logic [1:0]                Htrans,
  output logic [31:0]               Haddr,
  output logic                      Hwrite,
  output logic [31:0]               Hwdata
);

  localparam int unsigned     CntW   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [IdxW-1:0] DefIdx = IdxW'(DEF_MASTER);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BEATS - 1);

  htrans_t     trans_arr [NUM_MASTERS];
  logic [31:0] addr_arr  [NUM_MASTERS];
  logic [31:0] wdata_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign trans_arr[i] = htrans_t'(Htrans_m[2*i +: 2]);
    assign addr_arr[i]  = Haddr_m[32*i +: 32];
    assign wdata_arr[i] = Hwdata_m[32*i +: 32];
  end

  arb_state_t             state_q, state_d;
  logic [IdxW-1:0]        addr_owner_q, addr_owner_d;
  logic [IdxW-1:0]        data_owner_q;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                   mastlock_q;

  logic [NUM_MASTERS-1:0] owner_mask;
  logic [NUM_MASTERS-1:0] cand_gnt;
  logic [IdxW-1:0]        cand_idx;
  logic                   cand_valid;
  htrans_t                own_trans;
  logic                   own_req, own_lock, own_beat, others_req, rearb;

  rr_priority_picker #(
    .NumReq (NUM_MASTERS),
    .IdxW   (IdxW)
  ) u_picker (
    .req_i   (Hbusreq),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (cand_gnt),
    .idx_o   (cand_idx),
    .valid_o (cand_valid)
  );

  assign owner_mask = NUM_MASTERS'(1) << addr_owner_q;
  assign own_trans  = trans_arr[addr_owner_q];
  assign own_req    = Hbusreq[addr_owner_q];
  assign own_lock   = Hlock[addr_owner_q];
  assign own_beat   = is_beat(own_trans);
  assign others_req = |(Hbusreq & ~owner_mask);

  always_comb begin
    state_d      = state_q;
    addr_owner_d = addr_owner_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    rearb        = 1'b0;
    case (state_q)
      PARK:   rearb = |Hbusreq;
      OWNED: begin
        // A lock request from the owner wins over every handover reason.
        if (own_req && own_lock) begin
          state_d = LOCKED;
        end else if (!own_req || (own_trans == IDLE && others_req) ||
                     (beat_cnt_q == CntMax && own_beat && others_req)) begin
          rearb = 1'b1;
        end else if (own_beat && beat_cnt_q != CntMax) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      LOCKED: rearb = !own_lock && (own_trans == IDLE);
      default: ;
    endcase
    if (rearb) begin
      beat_cnt_d = '0;
      if (cand_valid) begin
        addr_owner_d = cand_idx;
        rr_ptr_d     = cand_idx;
        state_d      = Hlock[cand_idx] ? LOCKED : OWNED;
      end else begin
        addr_owner_d = DefIdx;
        state_d      = PARK;
      end
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q      <= PARK;
      addr_owner_q <= DefIdx;
      data_owner_q <= DefIdx;
      rr_ptr_q     <= DefIdx;
      beat_cnt_q   <= '0;
      mastlock_q   <= 1'b0;
    end else if (Hready) begin
      state_q      <= state_d;
      addr_owner_q <= addr_owner_d;
      data_owner_q <= addr_owner_q;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      mastlock_q   <= (state_d == LOCKED);
    end
  end

  assign Hgrant    = owner_mask;
  assign Hmaster   = addr_owner_q;
  assign Hmaster_d = data_owner_q;
  assign Hmastlock = mastlock_q;
  assign Htrans    = (state_q == PARK) ? IDLE : own_trans;
  assign Haddr     = addr_arr[addr_owner_q];
  assign Hwrite    = Hwrite_m[addr_owner_q];
  assign Hwdata    = wdata_arr[data_owner_q];

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Scoreboard bench for ahb_bridge_arbiter: directed scenarios then random traffic vs a reference model.
module tb_ahb_bridge_arbiter;

  localparam int N    = 3;
  localparam int DEF  = 0;
  localparam int MAXB = 16;

  typedef struct packed {
    logic [2:0]  grant;
    logic [1:0]  master;
    logic [1:0]  master_d;
    logic        mastlock;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } exp_t;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic [2:0]  Hbusreq = '0, Hlock = '0, Hwrite_m = '0;
  logic [5:0]  Htrans_m = '0;
  logic [95:0] Haddr_m = '0, Hwdata_m = '0;
  logic        Hready = 1'b1;
  logic [2:0]  Hgrant;
  logic [1:0]  Hmaster, Hmaster_d, Htrans;
  logic        Hmastlock, Hwrite;
  logic [31:0] Haddr, Hwdata;

  ahb_bridge_arbiter #(
    .NUM_MASTERS (N),
    .DEF_MASTER  (DEF),
    .MAX_BEATS   (MAXB)
  ) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Hbusreq   (Hbusreq),
    .Hlock     (Hlock),
    .Htrans_m  (Htrans_m),
    .Haddr_m   (Haddr_m),
    .Hwrite_m  (Hwrite_m),
    .Hwdata_m  (Hwdata_m),
    .Hready    (Hready),
    .Hgrant    (Hgrant),
    .Hmaster   (Hmaster),
    .Hmaster_d (Hmaster_d),
    .Hmastlock (Hmastlock),
    .Htrans    (Htrans),
    .Haddr     (Haddr),
    .Hwrite    (Hwrite),
    .Hwdata    (Hwdata)
  );

  always #5 Hclk = ~Hclk;

  // Stimulus for the next cycle, applied at the falling edge.
  logic        nx_rstn, nx_ready;
  logic [2:0]  nx_req, nx_lock, nx_write;
  logic [1:0]  nx_trans [N];
  logic [31:0] nx_addr  [N];
  logic [31:0] nx_wdata [N];

  // Reference model: who owns the address and data phases, and how the tenure is going.
  int m_owner, m_data_owner, m_tenure, m_last;
  bit m_parked, m_locked;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic int next_req(int ptr);
    for (int k = 1; k <= N; k++) begin
      if (nx_req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = DEF; m_data_owner = DEF; m_tenure = 0; m_last = DEF;
    m_parked = 1'b1; m_locked = 1'b0;
  endtask

  task automatic model_edge();
    int  own, c;
    bit  beat, others, sw;
    own    = m_owner;
    beat   = (nx_trans[own] == 2'd2) || (nx_trans[own] == 2'd3);
    others = (nx_req & ~(3'b001 << own)) != 3'b000;
    sw     = 1'b0;
    if (m_parked) begin
      sw = nx_req != 3'b000;
    end else if (m_locked) begin
      sw = !nx_lock[own] && nx_trans[own] == 2'd0;
    end else if (nx_req[own] && nx_lock[own]) begin
      m_locked = 1'b1;
    end else if (!nx_req[own] || (nx_trans[own] == 2'd0 && others) ||
                 (m_tenure >= MAXB - 1 && beat && others)) begin
      sw = 1'b1;
    end else if (beat) begin
      m_tenure++;
    end
    m_data_owner = own;
    if (sw) begin
      m_tenure = 0;
      c = next_req(m_last);
      if (c >= 0) begin
        m_owner = c; m_last = c; m_parked = 1'b0; m_locked = nx_lock[c];
      end else begin
        m_owner = DEF; m_parked = 1'b1; m_locked = 1'b0;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge Hclk);
    Hresetn  = nx_rstn;
    Hready   = nx_ready;
    Hbusreq  = nx_req;
    Hlock    = nx_lock;
    Hwrite_m = nx_write;
    for (int i = 0; i < N; i++) begin
      Htrans_m[2*i +: 2]  = nx_trans[i];
      Haddr_m[32*i +: 32] = nx_addr[i];
      Hwdata_m[32*i +: 32] = nx_wdata[i];
    end
    if (!nx_rstn) model_reset();
    #1;
    e.grant    = 3'b001 << m_owner;
    e.master   = 2'(m_owner);
    e.master_d = 2'(m_data_owner);
    e.mastlock = m_locked;
    e.trans    = m_parked ? 2'd0 : nx_trans[m_owner];
    e.addr     = nx_addr[m_owner];
    e.write    = nx_write[m_owner];
    e.wdata    = nx_wdata[m_data_owner];
    exp_q.push_back(e);
    if (nx_rstn && nx_ready) model_edge();
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] lock, input logic [1:0] t,
                       input logic ready, input int cycles);
    nx_req = req; nx_lock = lock; nx_ready = ready;
    for (int i = 0; i < N; i++) nx_trans[i] = t;
    for (int c = 0; c < cycles; c++) step();
  endtask

  // Monitor: the arbiter presents a full output set every cycle.
  initial begin : monitor
    exp_t e, got;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge Hclk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {Hgrant, Hmaster, Hmaster_d, Hmastlock, Htrans, Haddr, Hwrite, Hwdata};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL scoreboard cycle %0d: got grant=%b m=%0d md=%0d lock=%b tr=%0d addr=%h w=%b wd=%h; expected grant=%b m=%0d md=%0d lock=%b tr=%0d addr=%h w=%b wd=%h",
                   cyc, got.grant, got.master, got.master_d, got.mastlock, got.trans, got.addr,
                   got.write, got.wdata, e.grant, e.master, e.master_d, e.mastlock, e.trans,
                   e.addr, e.write, e.wdata);
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    nx_rstn = 1'b0; nx_ready = 1'b1; nx_req = '0; nx_lock = '0; nx_write = '0;
    for (int i = 0; i < N; i++) begin
      nx_trans[i] = 2'd0;
      nx_addr[i]  = 32'h1000_0000 * (i + 1);
      nx_wdata[i] = 32'hD000_0000 + i;
    end
    model_reset();

    // Reset and park with no requests.
    drive(3'b000, 3'b000, 2'd0, 1'b1, 3);
    nx_rstn = 1'b1;
    drive(3'b000, 3'b000, 2'd3, 1'b1, 4);

    // Two masters bursting SEQ: tenures rotate on the beat budget.
    drive(3'b110, 3'b000, 2'd3, 1'b1, 70);

    // Locked 40-beat burst from M1 while M2 waits.
    drive(3'b000, 3'b000, 2'd0, 1'b1, 2);
    drive(3'b010, 3'b000, 2'd2, 1'b1, 1);
    drive(3'b110, 3'b010, 2'd3, 1'b1, 41);
    nx_trans[1] = 2'd3;
    drive(3'b110, 3'b010, 2'd3, 1'b1, 0);
    nx_trans[1] = 2'd0; nx_lock = 3'b000;
    step();
    drive(3'b100, 3'b000, 2'd3, 1'b1, 3);

    // Stall across a handover request.
    drive(3'b010, 3'b000, 2'd3, 1'b1, 3);
    drive(3'b001, 3'b000, 2'd3, 1'b0, 5);
    drive(3'b001, 3'b000, 2'd3, 1'b1, 3);

    // M0 write then M2 takes the bus: data phase stays with M0.
    drive(3'b000, 3'b000, 2'd0, 1'b1, 2);
    nx_addr[0] = 32'h0000_0010; nx_wdata[0] = 32'hA5A5_0001; nx_write = 3'b001;
    drive(3'b001, 3'b000, 2'd2, 1'b1, 2);
    nx_addr[2] = 32'h0000_0200;
    drive(3'b100, 3'b000, 2'd2, 1'b1, 3);

    // Asynchronous reset in the middle of a locked burst.
    drive(3'b010, 3'b010, 2'd3, 1'b1, 6);
    nx_rstn = 1'b0;
    drive(3'b010, 3'b010, 2'd3, 1'b1, 2);
    nx_rstn = 1'b1;
    drive(3'b010, 3'b000, 2'd3, 1'b1, 4);

    // Random traffic with sticky requests and occasional resets.
    nx_req = '0; nx_lock = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) nx_req[i] = ~nx_req[i];
        if ($urandom_range(0, 29) == 0) nx_lock[i] = 1'b1;
        else if ($urandom_range(0, 4) == 0) nx_lock[i] = 1'b0;
        r = $urandom_range(0, 9);
        nx_trans[i] = (r < 1) ? 2'd0 : (r < 2) ? 2'd1 : (r < 4) ? 2'd2 : 2'd3;
        nx_addr[i]  = $urandom;
        nx_wdata[i] = $urandom;
        nx_write[i] = 1'($urandom_range(0, 1));
      end
      nx_ready = ($urandom_range(0, 4) != 0);
      nx_rstn  = ($urandom_range(0, 399) != 0);
      step();
    end

    @(negedge Hclk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
